// File: rtl/mux_addr_driver.sv
// Break-before-make driver for the external 16:1 analog mux address pins and enable.
// Address changes open the mux for a dead time, apply the new address, then wait a settle time before re-enabling.
module mux_addr_driver #(
    parameter int DEAD_CYCLES   = 50,
    parameter int SETTLE_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel3,
    input  logic        sel2,
    input  logic        sel1,
    input  logic        sel0,
    input  logic        enable_req,
    output logic [3:0]  mux_a,
    output logic        mux_en,
    output logic        busy,
    output logic [15:0] switch_count
);

    localparam int MAX_CYCLES = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ON     = 2'd2,
        BREAK  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_sel_meta;
    logic [3:0]        r_tgt;
    logic              r_en_meta;
    logic              r_en_s;
    logic [3:0]        r_mux_a;
    logic              r_mux_en;
    logic              r_busy;
    logic [15:0]       r_switch_count;

    logic [3:0]        w_sel;
    logic              w_addr_change;

    assign w_sel         = {sel3, sel2, sel1, sel0};
    assign w_addr_change = (r_tgt != r_mux_a);

    // The inputs come from switches, so both the address and the enable get two flops before the FSM sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_meta     <= 4'd0;
            r_tgt          <= 4'd0;
            r_en_meta      <= 1'b0;
            r_en_s         <= 1'b0;
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_mux_a        <= 4'd0;
            r_mux_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_switch_count <= 16'd0;
        end else begin
            r_sel_meta <= w_sel;
            r_tgt      <= r_sel_meta;
            r_en_meta  <= enable_req;
            r_en_s     <= r_en_meta;

            case (r_state)
                IDLE: begin
                    r_mux_en <= 1'b0;
                    r_mux_a  <= r_tgt;
                    if (w_addr_change) begin
                        r_switch_count <= r_switch_count + 16'd1;
                    end
                    if (r_en_s) begin
                        r_cnt   <= SETTLE_LOAD;
                        r_state <= SETTLE;
                        r_busy  <= 1'b1;
                    end
                end

                SETTLE: begin
                    if (!r_en_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_addr_change) begin
                        // Mux is already open here, so the new address goes out at once and settling restarts.
                        r_mux_a        <= r_tgt;
                        r_switch_count <= r_switch_count + 16'd1;
                        r_cnt          <= SETTLE_LOAD;
                    end else if (r_cnt == '0) begin
                        r_mux_en <= 1'b1;
                        r_state  <= ON;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ON: begin
                    if (!r_en_s) begin
                        r_mux_en <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_addr_change) begin
                        r_mux_en <= 1'b0;
                        r_cnt    <= DEAD_LOAD;
                        r_state  <= BREAK;
                        r_busy   <= 1'b1;
                    end
                end

                BREAK: begin
                    if (!r_en_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        // Apply whatever is requested now, even if it equals the address already on the pins.
                        r_mux_a        <= r_tgt;
                        r_switch_count <= r_switch_count + 16'd1;
                        r_cnt          <= SETTLE_LOAD;
                        r_state        <= SETTLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_mux_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign mux_a        = r_mux_a;
    assign mux_en       = r_mux_en;
    assign busy         = r_busy;
    assign switch_count = r_switch_count;

endmodule

// File: tb/tb_mux_addr_driver.sv
// Bench for mux_addr_driver with DEAD_CYCLES=4, SETTLE_CYCLES=3: per-cycle vector table plus reset sequences.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_mux_addr_driver;

    localparam int D = 4;
    localparam int S = 3;
    localparam int N_VEC = 74;

    logic        clk;
    logic        rst;
    logic        sel3, sel2, sel1, sel0;
    logic        enable_req;
    logic [3:0]  mux_a;
    logic        mux_en;
    logic        busy;
    logic [15:0] switch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [21:0] exp_q[$];

    typedef struct packed {
        logic [3:0]  sel;
        logic        en;
        logic [3:0]  a;
        logic        men;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[N_VEC];

    mux_addr_driver #(
        .DEAD_CYCLES   (D),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel3         (sel3),
        .sel2         (sel2),
        .sel1         (sel1),
        .sel0         (sel0),
        .enable_req   (enable_req),
        .mux_a        (mux_a),
        .mux_en       (mux_en),
        .busy         (busy),
        .switch_count (switch_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input int s, input int e, input int a, input int m, input int b, input int c);
        vec_t r;
        r.sel  = 4'(s);
        r.en   = 1'(e);
        r.a    = 4'(a);
        r.men  = 1'(m);
        r.busy = 1'(b);
        r.cnt  = 16'(c);
        return r;
    endfunction

    task automatic drive(input logic [3:0] s, input logic e);
        {sel3, sel2, sel1, sel0} = s;
        enable_req = e;
    endtask

    task automatic push_exp(input logic [3:0] a, input logic m, input logic b, input logic [15:0] c);
        exp_q.push_back({a, m, b, c});
    endtask

    task automatic check_out(input string name);
        logic [21:0] exp_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp_v = exp_q.pop_front();
            if ({mux_a, mux_en, busy, switch_count} !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got mux_a=%h mux_en=%b busy=%b count=%0d, want mux_a=%h mux_en=%b busy=%b count=%0d",
                         name, mux_a, mux_en, busy, switch_count,
                         exp_v[21:18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
        end
    endtask

    // Break-before-make monitor: mux_a must never move while enabled, nor on the edge mux_en rises.
    logic       mon_valid = 1'b0;
    logic [3:0] prev_a;
    logic       prev_en;
    always @(negedge clk) begin
        if (rst) begin
            mon_valid <= 1'b0;
        end else begin
            if (mon_valid) begin
                n_checks++;
                if (mux_a != prev_a && (prev_en || mux_en)) begin
                    n_fail++;
                    $display("FAIL bbm_order: mux_a %h->%h with mux_en %b->%b", prev_a, mux_a, prev_en, mux_en);
                end
            end
            mon_valid <= 1'b1;
        end
        prev_a  <= mux_a;
        prev_en <= mux_en;
    end

    initial begin
        // Enable rise, address switch in ON, change during BREAK, change during SETTLE,
        // return-to-same during BREAK, disable mid-BREAK, IDLE tracking, enable rise and fall.
        tbl[0]  = v(5,1, 0,0,0,0);  tbl[1]  = v(5,1, 0,0,0,0);
        tbl[2]  = v(5,1, 5,0,1,1);  tbl[3]  = v(5,1, 5,0,1,1);
        tbl[4]  = v(5,1, 5,0,1,1);  tbl[5]  = v(5,1, 5,1,0,1);
        tbl[6]  = v(5,1, 5,1,0,1);
        tbl[7]  = v(10,1, 5,1,0,1); tbl[8]  = v(10,1, 5,1,0,1);
        tbl[9]  = v(10,1, 5,0,1,1); tbl[10] = v(10,1, 5,0,1,1);
        tbl[11] = v(10,1, 5,0,1,1); tbl[12] = v(10,1, 5,0,1,1);
        tbl[13] = v(10,1, 10,0,1,2); tbl[14] = v(10,1, 10,0,1,2);
        tbl[15] = v(10,1, 10,0,1,2); tbl[16] = v(10,1, 10,1,0,2);
        tbl[17] = v(10,1, 10,1,0,2);
        tbl[18] = v(5,1, 10,1,0,2); tbl[19] = v(5,1, 10,1,0,2);
        tbl[20] = v(12,1, 10,0,1,2); tbl[21] = v(12,1, 10,0,1,2);
        tbl[22] = v(12,1, 10,0,1,2); tbl[23] = v(12,1, 10,0,1,2);
        tbl[24] = v(12,1, 12,0,1,3); tbl[25] = v(12,1, 12,0,1,3);
        tbl[26] = v(12,1, 12,0,1,3); tbl[27] = v(12,1, 12,1,0,3);
        tbl[28] = v(12,1, 12,1,0,3);
        tbl[29] = v(3,1, 12,1,0,3); tbl[30] = v(3,1, 12,1,0,3);
        tbl[31] = v(3,1, 12,0,1,3); tbl[32] = v(3,1, 12,0,1,3);
        tbl[33] = v(3,1, 12,0,1,3); tbl[34] = v(6,1, 12,0,1,3);
        tbl[35] = v(6,1, 3,0,1,4);  tbl[36] = v(6,1, 6,0,1,5);
        tbl[37] = v(6,1, 6,0,1,5);  tbl[38] = v(6,1, 6,0,1,5);
        tbl[39] = v(6,1, 6,1,0,5);  tbl[40] = v(6,1, 6,1,0,5);
        tbl[41] = v(9,1, 6,1,0,5);  tbl[42] = v(6,1, 6,1,0,5);
        tbl[43] = v(6,1, 6,0,1,5);  tbl[44] = v(6,1, 6,0,1,5);
        tbl[45] = v(6,1, 6,0,1,5);  tbl[46] = v(6,1, 6,0,1,5);
        tbl[47] = v(6,1, 6,0,1,6);  tbl[48] = v(6,1, 6,0,1,6);
        tbl[49] = v(6,1, 6,0,1,6);  tbl[50] = v(6,1, 6,1,0,6);
        tbl[51] = v(6,1, 6,1,0,6);
        tbl[52] = v(2,1, 6,1,0,6);  tbl[53] = v(2,1, 6,1,0,6);
        tbl[54] = v(2,1, 6,0,1,6);  tbl[55] = v(2,0, 6,0,1,6);
        tbl[56] = v(2,0, 6,0,1,6);  tbl[57] = v(2,0, 6,0,0,6);
        tbl[58] = v(2,0, 2,0,0,7);  tbl[59] = v(2,0, 2,0,0,7);
        tbl[60] = v(15,0, 2,0,0,7); tbl[61] = v(15,0, 2,0,0,7);
        tbl[62] = v(15,0, 15,0,0,8); tbl[63] = v(15,0, 15,0,0,8);
        tbl[64] = v(15,1, 15,0,0,8); tbl[65] = v(15,1, 15,0,0,8);
        tbl[66] = v(15,1, 15,0,1,8); tbl[67] = v(15,1, 15,0,1,8);
        tbl[68] = v(15,1, 15,0,1,8); tbl[69] = v(15,1, 15,1,0,8);
        tbl[70] = v(15,0, 15,1,0,8); tbl[71] = v(15,0, 15,1,0,8);
        tbl[72] = v(15,0, 15,0,0,8); tbl[73] = v(15,0, 15,0,0,8);

        // Reset with random inputs
        rst = 1'b1;
        drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        push_exp(4'h0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        check_out("reset_first_edge");
        for (int i = 0; i < 2; i++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            push_exp(4'h0, 1'b0, 1'b0, 16'd0);
            @(posedge clk);
            @(negedge clk);
            check_out("reset_hold");
        end
        drive(4'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < N_VEC; i++) begin
            drive(tbl[i].sel, tbl[i].en);
            push_exp(tbl[i].a, tbl[i].men, tbl[i].busy, tbl[i].cnt);
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
        end

        // Reset in the middle of SETTLE
        drive(4'hF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) break;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL settle_entry: busy=%b want 1 within 10 cycles", busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_exp(4'h0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        check_out("reset_mid_settle");
        drive(4'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(4'h0, 1'b0, 1'b0, 16'd0);
            @(posedge clk);
            @(negedge clk);
            check_out("post_reset_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_addr_driver.md
# mux_addr_driver

Output stage for the stimulation channel-select path. Takes the 4-bit analog-multiplexer address produced by the channel address multiplexer (sel3..sel0), synchronizes it, and drives the external 16:1 analog mux address pins and enable with break-before-make sequencing. On every address change the mux is disabled for a dead time, the new address is applied, and the mux is re-enabled only after a settle time, so two electrodes are never connected to the stimulus line at once.

## Interface
- DEAD_CYCLES, 50: clk cycles mux_en is held low before a new address is applied; legal range ≥1.
- SETTLE_CYCLES, 20: clk cycles after the address is applied before mux_en rises; legal range ≥1.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- sel3, sel2, sel1, sel0  in  1 each  requested mux address, MSB first; asynchronous to clk (switch-derived).
- enable_req  in  1  stimulation enable request; asynchronous to clk.
- mux_a  out  4  registered address to the analog mux pins.
- mux_en  out  1  registered analog mux enable; active-high.
- busy  out  1  high while in BREAK or SETTLE.
- switch_count  out  16  number of addresses applied since reset; wraps 0xFFFF→0x0000.

## Operation
- Synchronizer: {sel3..sel0} and enable_req each pass through a 2-flop synchronizer; tgt = synchronized address, en_s = synchronized enable. The FSM uses only tgt and en_s.
- Counters: width $clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1); one shared down-counter cnt.
- States:
  - IDLE: mux_en=0; mux_a <= tgt every cycle (increments switch_count when the value changes). If en_s=1: cnt<=SETTLE_CYCLES-1, go SETTLE.
  - SETTLE: mux_en=0. If en_s=0: go IDLE. Else if tgt≠mux_a: mux_a<=tgt, switch_count++, cnt<=SETTLE_CYCLES-1 (restart settle; no dead time needed, mux is already off). Else if cnt=0: mux_en<=1, go ON. Else cnt--.
  - ON: mux_en=1. If en_s=0: mux_en<=0, go IDLE. Else if tgt≠mux_a: mux_en<=0, cnt<=DEAD_CYCLES-1, go BREAK.
  - BREAK: mux_en=0; mux_a unchanged. If en_s=0: go IDLE. Else if cnt=0: mux_a<=tgt (current value, not the value that triggered BREAK), switch_count++, cnt<=SETTLE_CYCLES-1, go SETTLE. Else cnt--.
- Address changes during BREAK only change what is applied at BREAK exit; they do not restart the dead time.
- If tgt returns to the current mux_a during BREAK, BREAK still completes, the address is re-applied unchanged (switch_count still increments), and SETTLE follows.
- en_s=0 has priority over every other condition in every state.
- mux_en never rises in the same cycle mux_a changes; mux_a never changes while mux_en=1.
- Reset: state IDLE, mux_a=0, mux_en=0, busy=0, switch_count=0, cnt=0, all synchronizer flops 0. Reset mid-operation aborts any BREAK/SETTLE on the next edge.

## Timing
- Input sampled at edge e is visible as tgt/en_s after edge e+1; the FSM acts at edge e+2 (t0).
- Address change in ON, with enable held: mux_en falls at t0; mux_a updates at t0+DEAD_CYCLES; mux_en rises at t0+DEAD_CYCLES+SETTLE_CYCLES. mux_en is low for exactly DEAD_CYCLES+SETTLE_CYCLES cycles.
- Enable rise from IDLE: SETTLE entered at t0; mux_en rises at t0+SETTLE_CYCLES.
- Enable fall: mux_en low at t0 from any state.
- busy is registered together with the state: high from t0 through the cycle before mux_en rises.

## Test plan
- Reset: assert rst for 3 cycles with random inputs → mux_a=0, mux_en=0, busy=0, switch_count=0 on the cycle after the first reset edge.
- Enable (D=4, S=3): sel=0x5, enable_req rises at edge e → mux_a=0x5 already applied in IDLE; mux_en=1 at e+5; switch_count=1.
- Address switch: in ON at 0x5, sel→0xA at edge e → mux_en=0 at e+2; mux_a=0xA at e+6; mux_en=1 at e+9; switch_count=2; mux_en and mux_a never change on the same edge.
- Change during BREAK: sel 0x5→0xA, then →0xC two cycles later → mux_a goes 0x5→0xC directly at e+6 (0xA never driven); mux_en=1 at e+9.
- Change during SETTLE: second change lands during SETTLE → mux_a updates immediately; settle restarts; mux_en rises SETTLE_CYCLES after the last update.
- Disable mid-BREAK, then mid-operation rst: enable_req falls during BREAK → IDLE, mux_en stays 0, mux_a tracks tgt. rst during SETTLE → all outputs return to reset values on the next edge.
